// File: rtl/ac_motor_pkg.sv
// ac_motor_pkg
// Shared definitions for the AC motor gate driver:
//   - per-phase state encoding
//   - space-vector constants, written as S[2:0] with S[0] = phase 1
//   - ZERO_MODE encodings
//   - active_vec(): selects the active vector for a sector and step
package ac_motor_pkg;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_DT   = 2'd1,
    PH_ON_H = 2'd2,
    PH_ON_L = 2'd3
  } phase_state_e;

  localparam logic [2:0] VEC_V0 = 3'b000;
  localparam logic [2:0] VEC_V1 = 3'b001;
  localparam logic [2:0] VEC_V2 = 3'b011;
  localparam logic [2:0] VEC_V3 = 3'b010;
  localparam logic [2:0] VEC_V4 = 3'b110;
  localparam logic [2:0] VEC_V5 = 3'b100;
  localparam logic [2:0] VEC_V6 = 3'b101;
  localparam logic [2:0] VEC_V7 = 3'b111;

  localparam int ZM_V0  = 0;
  localparam int ZM_V7  = 1;
  localparam int ZM_ALT = 2;

  // Returns V((sector + step) mod 6), where index 0 maps to V6.
  // The caller only passes sectors 0..5, so one subtraction of 6 is enough.
  function automatic logic [2:0] active_vec(input logic [2:0] sector,
                                            input logic [1:0] step);
    logic [3:0] idx;
    idx = {1'b0, sector} + {2'b00, step};
    if (idx >= 4'd6) idx = idx - 4'd6;
    case (idx)
      4'd1:    active_vec = VEC_V1;
      4'd2:    active_vec = VEC_V2;
      4'd3:    active_vec = VEC_V3;
      4'd4:    active_vec = VEC_V4;
      4'd5:    active_vec = VEC_V5;
      default: active_vec = VEC_V6;
    endcase
  endfunction

endpackage

// File: rtl/ac_motor_deadtime_phase.sv
// ac_motor_deadtime_phase
// Gate sequencer for one inverter phase, with a dead-time down-counter.
//
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   run              1 = drive allowed (enabled and no trip); 0 forces OFF
//   target           wanted switch level for this phase
//   dead_time        dead-time length in clk cycles, loaded on each (re)start
//   gate_h, gate_l   high-side and low-side gate outputs
//   in_dt            phase is currently in dead time
//
// state | meaning
// ------+---------------------------------------------------------------
// OFF   | not driving; both gates low; waits for run
// DT    | dead time; both gates low; counter runs toward the pending level
// ON_H  | high side on
// ON_L  | low side on
module ac_motor_deadtime_phase
  import ac_motor_pkg::*;
#(
  parameter int DT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            target,
  input  logic [DT_W-1:0] dead_time,
  output logic            gate_h,
  output logic            gate_l,
  output logic            in_dt
);

  phase_state_e    state_q, state_d;
  logic            lvl_q, lvl_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0] cnt_dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_OFF;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter saturates at zero. A load of 0 or 1 therefore still gives
  // exactly one dead cycle.
  assign cnt_dec = (cnt_q == '0) ? '0 : cnt_q - DT_W'(1);

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    if (!run) begin
      state_d = PH_OFF;
      cnt_d   = '0;
    end else begin
      case (state_q)
        PH_OFF: begin
          state_d = PH_DT;
          lvl_d   = target;
          cnt_d   = dead_time;
        end
        PH_DT: begin
          if (target != lvl_q) begin
            // A reversal during dead time restarts the full dead time.
            lvl_d = target;
            cnt_d = dead_time;
          end else begin
            cnt_d = cnt_dec;
            if (cnt_dec == '0) state_d = lvl_q ? PH_ON_H : PH_ON_L;
          end
        end
        PH_ON_H, PH_ON_L: begin
          if (target != lvl_q) begin
            state_d = PH_DT;
            lvl_d   = target;
            cnt_d   = dead_time;
          end
        end
        default: state_d = PH_OFF;
      endcase
    end
  end

  // Gates are decoded from registered state only, so reset clears them at once
  // and the two sides of a phase can never be on together.
  assign gate_h = (state_q == PH_ON_H);
  assign gate_l = (state_q == PH_ON_L);
  assign in_dt  = (state_q == PH_DT);

endmodule

// File: rtl/ac_motor_gate_drive.sv
// ac_motor_gate_drive
// Space-vector gate driver for a three-phase inverter. The requests select a
// registered target vector S, and each phase moves its gates to the target
// level through a dead-time interval.
//
// Optional feature: define AC_MOTOR_GATE_FAULT_EN to enable the latched
// external trip (fault / fault_clr). Without it, both inputs are ignored and
// fault_latched is held at 0.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   en                drive enable; 0 sends every phase to OFF
//   sector            space-vector sector 0..5 (6 and 7 hold S)
//   u_0, u_1, u_2     request zero / first-active / second-active vector
//   dead_time         dead time in clk cycles
//   fault, fault_clr  external trip and trip clear
//   gate_h, gate_l    gate drives per phase, bit 0 = phase 1
//   s                 registered target switch state, bit 0 = phase 1
//   busy              any phase in dead time
//   fault_latched     trip active
module ac_motor_gate_drive
  import ac_motor_pkg::*;
#(
  parameter int DT_W      = 8,
  parameter int ZERO_MODE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [2:0]      sector,
  input  logic            u_0,
  input  logic            u_1,
  input  logic            u_2,
  input  logic [DT_W-1:0] dead_time,
  input  logic            fault,
  input  logic            fault_clr,
  output logic [2:0]      gate_h,
  output logic [2:0]      gate_l,
  output logic [2:0]      s,
  output logic            busy,
  output logic            fault_latched
);

  logic [2:0] s_q, s_d;
  logic       tog_q, tog_d;
  logic       fault_latched_q, fault_latched_d;
  logic [2:0] zero_vec;
  logic [2:0] in_dt;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q             <= VEC_V0;
      tog_q           <= 1'b0;
      fault_latched_q <= 1'b0;
    end else begin
      s_q             <= s_d;
      tog_q           <= tog_d;
      fault_latched_q <= fault_latched_d;
    end
  end

  always_comb begin
    if (ZERO_MODE == ZM_V7)       zero_vec = VEC_V7;
    else if (ZERO_MODE == ZM_ALT) zero_vec = tog_q ? VEC_V7 : VEC_V0;
    else                          zero_vec = VEC_V0;
  end

  // An invalid sector holds S for every request, including u_0. The
  // alternating zero vector advances only when it is actually loaded.
  always_comb begin
    s_d   = s_q;
    tog_d = tog_q;
    if (sector <= 3'd5) begin
      if (u_0) begin
        s_d = zero_vec;
        if (ZERO_MODE == ZM_ALT) tog_d = ~tog_q;
      end else if (u_1) begin
        s_d = active_vec(sector, 2'd1);
      end else if (u_2) begin
        s_d = active_vec(sector, 2'd2);
      end
    end
  end

`ifdef AC_MOTOR_GATE_FAULT_EN
  // If fault and fault_clr are high together, fault wins.
  always_comb begin
    fault_latched_d = fault_latched_q;
    if (fault)          fault_latched_d = 1'b1;
    else if (fault_clr) fault_latched_d = 1'b0;
  end
`else
  logic fault_unused;
  assign fault_unused    = fault ^ fault_clr;
  assign fault_latched_d = 1'b0;
`endif

  // Using the next trip value makes a trip turn the gates off on the same
  // edge that latches it.
  assign run = en & ~fault_latched_d;

  for (genvar i = 0; i < 3; i++) begin : g_phase
    ac_motor_deadtime_phase #(
      .DT_W(DT_W)
    ) u_phase (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .target   (s_q[i]),
      .dead_time(dead_time),
      .gate_h   (gate_h[i]),
      .gate_l   (gate_l[i]),
      .in_dt    (in_dt[i])
    );
  end

  assign s             = s_q;
  assign busy          = |in_dt;
  assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_ac_motor_gate_drive.sv
module tb_ac_motor_gate_drive;

  localparam int DT_W      = 8;
  localparam int ZERO_MODE = 2;
`ifdef AC_MOTOR_GATE_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [2:0]      sector;
  logic            u_0, u_1, u_2;
  logic [DT_W-1:0] dead_time;
  logic            fault, fault_clr;
  logic [2:0]      gate_h, gate_l, s;
  logic            busy, fault_latched;

  int errors = 0;
  int checks = 0;

  ac_motor_gate_drive #(
    .DT_W     (DT_W),
    .ZERO_MODE(ZERO_MODE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sector       (sector),
    .u_0          (u_0),
    .u_1          (u_1),
    .u_2          (u_2),
    .dead_time    (dead_time),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .gate_h       (gate_h),
    .gate_l       (gate_l),
    .s            (s),
    .busy         (busy),
    .fault_latched(fault_latched)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model. Each phase keeps an "earliest on" cycle. A dead-time
  // window of max(D,1) cycles restarts whenever the phase is enabled from off
  // or its target differs from the level it is heading for.
  logic [2:0] vt [6] = '{3'b101, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100};
  logic [2:0] m_s;
  bit         m_tog, m_fl;
  bit         m_act [3];
  bit         m_lvl [3];
  int         m_ready [3];
  int         cyc = 0;

  task automatic model_reset();
    m_s = 3'b000; m_tog = 1'b0; m_fl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0; m_lvl[i] = 1'b0; m_ready[i] = 0;
    end
  endtask

  task automatic model_update();
    logic [2:0] old_s;
    int len;
    int sec;
    old_s = m_s;
    cyc++;
    if (FAULT_EN) begin
      if (fault) m_fl = 1'b1;
      else if (fault_clr) m_fl = 1'b0;
    end
    len = (dead_time == 0) ? 1 : int'(dead_time);
    for (int i = 0; i < 3; i++) begin
      if (!en || m_fl) m_act[i] = 1'b0;
      else if (!m_act[i] || (old_s[i] != m_lvl[i])) begin
        m_act[i] = 1'b1; m_lvl[i] = old_s[i]; m_ready[i] = cyc + len;
      end
    end
    sec = int'(sector);
    if (sec < 6) begin
      if (u_0) begin
        if (ZERO_MODE == 1) m_s = 3'b111;
        else if (ZERO_MODE == 2) m_s = m_tog ? 3'b111 : 3'b000;
        else m_s = 3'b000;
        if (ZERO_MODE == 2) m_tog = !m_tog;
      end else if (u_1) m_s = vt[(sec + 1) % 6];
      else if (u_2) m_s = vt[(sec + 2) % 6];
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    logic [2:0] eh, el;
    logic eb;
    eh = 3'b000; el = 3'b000; eb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (m_act[i] && cyc >= m_ready[i]) begin
        eh[i] = m_lvl[i]; el[i] = !m_lvl[i];
      end
      if (m_act[i] && cyc < m_ready[i]) eb = 1'b1;
    end
    chk("s", s, m_s);
    chk("gate_h", gate_h, eh);
    chk("gate_l", gate_l, el);
    chk("busy", busy, eb);
    chk("fault_latched", fault_latched, m_fl);
    chk("overlap", gate_h & gate_l, 3'b000);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic req(input logic [2:0] sec, input logic r0, input logic r1, input logic r2);
    sector = sec; u_0 = r0; u_1 = r1; u_2 = r2;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; dead_time = '0; fault = 1'b0; fault_clr = 1'b0;
    req(3'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #3;
    chk("rst_gate_h", gate_h, 3'b000);
    chk("rst_gate_l", gate_l, 3'b000);
    chk("rst_s", s, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fault", fault_latched, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Enable with DEAD_TIME=4 and a sector-0 first-active request.
    en = 1'b1; dead_time = 8'd4; req(3'd0, 1'b0, 1'b1, 1'b0);
    step();
    chk("s_after_1", s, 3'b001);
    chk("gates_off_1", gate_h | gate_l, 3'b000);
    for (int k = 2; k <= 4; k++) begin
      step();
      chk("gates_off_dt", gate_h | gate_l, 3'b000);
    end
    step();
    chk("p23_on_l", gate_l, 3'b110);
    chk("p1_still_off", gate_h, 3'b000);
    step();
    chk("p1_on_h", gate_h, 3'b001);
    chk("busy_clear", busy, 1'b0);

    // Sector wrap-around and invalid-sector hold.
    req(3'd5, 1'b0, 1'b1, 1'b0); step();
    chk("wrap_s5_u1", s, 3'b101);
    req(3'd5, 1'b0, 1'b0, 1'b1); step();
    chk("wrap_s5_u2", s, 3'b001);
    req(3'd7, 1'b0, 1'b1, 1'b0); step();
    chk("hold_s7", s, 3'b001);
    req(3'd6, 1'b0, 1'b0, 1'b1); step();
    chk("hold_s6", s, 3'b001);

    // Target reversal in dead time: phase 1 from 0 to 1 and back at DT cycle 3.
    req(3'd2, 1'b0, 1'b1, 1'b0); step();
    req(3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) step();
    chk("rev_pre_l0", gate_l[0], 1'b1);
    dead_time = 8'd6;
    req(3'd0, 1'b0, 1'b1, 1'b0); step();
    chk("rev_s_001", s, 3'b001);
    req(3'd0, 1'b0, 1'b0, 1'b0);
    step(); step();
    chk("rev_dt_c2", gate_h[0] | gate_l[0], 1'b0);
    req(3'd2, 1'b0, 1'b1, 1'b0); step();
    req(3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rev_low_h0", gate_h[0], 1'b0);
      chk("rev_low_l0", gate_l[0], 1'b0);
    end
    step();
    chk("rev_on_l0", gate_l[0], 1'b1);
    chk("rev_never_h0", gate_h[0], 1'b0);

    // Alternating zero vector with DEAD_TIME=0.
    dead_time = 8'd0;
    req(3'd0, 1'b1, 1'b0, 1'b0); step();
    chk("zero_1", s, 3'b000);
    req(3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step();
    chk("zero_settled", gate_l, 3'b111);
    req(3'd0, 1'b1, 1'b0, 1'b0); step();
    chk("zero_2", s, 3'b111);
    req(3'd0, 1'b0, 1'b0, 1'b0); step();
    chk("dt0_dead_busy", busy, 1'b1);
    chk("dt0_dead_gates", gate_h | gate_l, 3'b000);
    step();
    chk("dt0_on_h", gate_h, 3'b111);
    req(3'd0, 1'b1, 1'b0, 1'b0); step();
    chk("zero_3", s, 3'b000);
    req(3'd0, 1'b0, 1'b0, 1'b0); step();
    chk("dt0_dead2", gate_h | gate_l, 3'b000);
    step();
    chk("dt0_on_l", gate_l, 3'b111);

    // EN low in the middle of dead time.
    dead_time = 8'd5;
    req(3'd0, 1'b1, 1'b0, 1'b0); step();
    req(3'd0, 1'b0, 1'b0, 1'b0); step(); step();
    chk("en_pre_busy", busy, 1'b1);
    en = 1'b0; step();
    chk("en_off_busy", busy, 1'b0);
    chk("en_off_gates", gate_h | gate_l, 3'b000);
    en = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("en_back_on", gate_h, 3'b111);

    // Trip handling: fault while phases 2/3 are mid-DT.
    req(3'd0, 1'b0, 1'b1, 1'b0); step();
    req(3'd0, 1'b0, 1'b0, 1'b0); step(); step();
    fault = 1'b1; step();
    fault = 1'b0; step(); step();
    fault = 1'b1; fault_clr = 1'b1; step();
    fault = 1'b0; step();
    fault_clr = 1'b0;
    if (FAULT_EN) begin
      chk("clr_entered_dt", busy, 1'b1);
      for (int k = 0; k < 4; k++) begin
        step();
        chk("clr_full_dt", gate_h | gate_l, 3'b000);
      end
      step();
      chk("clr_on_h", gate_h, 3'b001);
      chk("clr_on_l", gate_l, 3'b110);
    end else begin
      chk("nofault_latched", fault_latched, 1'b0);
      for (int k = 0; k < 5; k++) step();
      chk("nofault_gates", gate_h, 3'b001);
    end

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      en        = ($urandom_range(0, 15) != 0);
      sector    = 3'($urandom_range(0, 7));
      u_0       = ($urandom_range(0, 7) == 0);
      u_1       = ($urandom_range(0, 3) == 0);
      u_2       = ($urandom_range(0, 3) == 0);
      if (u_0 && sector > 3'd5) sector = 3'($urandom_range(0, 5));
      dead_time = 8'($urandom_range(0, 6));
      fault     = ($urandom_range(0, 39) == 0);
      fault_clr = ($urandom_range(0, 5) == 0);
      step();
    end

    // Asynchronous reset in the middle of a cycle while gates are driving.
    en = 1'b1; fault = 1'b0; fault_clr = 1'b1; dead_time = 8'd2;
    req(3'd1, 1'b0, 1'b1, 1'b0); step();
    fault_clr = 1'b0; req(3'd0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    chk("pre_arst_on", gate_h | gate_l, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gate_h", gate_h, 3'b000);
    chk("arst_gate_l", gate_l, 3'b000);
    chk("arst_s", s, 3'b000);
    chk("arst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_arst_dt", busy, 1'b1);
    for (int k = 0; k < 3; k++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
